dmem_arbiter: RTL and testbench

//   Shares the single-port data RAM between two requesters: the core data port (C)
//   and a host/program-loader port (H) that preloads or inspects memory.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM port seen by dmem_arbiter.
// The arbiter takes the slave view; requesters, the RAM and the bench take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  c_req;
  logic                  c_rw;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_gnt;
  logic                  c_done;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  h_req;
  logic                  h_rw;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  h_gnt;
  logic                  h_done;
  logic [DATA_WIDTH-1:0] h_rdata;

  logic [ADDR_WIDTH-1:0] daddr;
  logic                  d_rw;
  logic [DATA_WIDTH-1:0] ddata_w;
  logic [DATA_WIDTH-1:0] ddata_r;

  modport slave (
    input  c_req, c_rw, c_addr, c_wdata,
    input  h_req, h_rw, h_addr, h_wdata,
    input  ddata_r,
    output c_gnt, c_done, c_rdata,
    output h_gnt, h_done, h_rdata,
    output daddr, d_rw, ddata_w
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata,
    output h_req, h_rw, h_addr, h_wdata,
    output ddata_r,
    input  c_gnt, c_done, c_rdata,
    input  h_gnt, h_done, h_rdata,
    input  daddr, d_rw, ddata_w
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the core (C) and host (H) ports.
// One access in flight: grant in IDLE, RAM access in ACCESS, done/rdata the following cycle.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic           CLK,
  input logic           RESET_N,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Port index 0 is the core, 1 is the host.
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_H = 1'b1;

  state_t                state_reg;
  logic                  owner_reg;
  logic                  last_owner_reg;
  logic                  rw_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic [1:0]            req;
  logic [1:0]            rw_in;
  logic [ADDR_WIDTH-1:0] addr_in  [2];
  logic [DATA_WIDTH-1:0] wdata_in [2];
  logic [1:0]            win;
  logic [1:0]            gnt;
  logic                  win_id;
  logic [1:0]            done_reg;
  logic [DATA_WIDTH-1:0] rdata_reg [2];

  assign req         = {bus.h_req, bus.c_req};
  assign rw_in       = {bus.h_rw, bus.c_rw};
  assign addr_in[0]  = bus.c_addr;
  assign addr_in[1]  = bus.h_addr;
  assign wdata_in[0] = bus.c_wdata;
  assign wdata_in[1] = bus.h_wdata;

  // On a tie the port that did not own the previous grant wins.
  assign win[0] = req[0] & (~req[1] | (last_owner_reg == OWN_H));
  assign win[1] = req[1] & (~req[0] | (last_owner_reg == OWN_C));
  assign win_id = win[1];
  assign gnt    = ((state_reg == IDLE) && RESET_N) ? win : 2'b00;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_C;
      last_owner_reg <= OWN_H;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|gnt) begin
            state_reg      <= ACCESS;
            owner_reg      <= win_id;
            last_owner_reg <= win_id;
            rw_reg         <= rw_in[win_id];
            addr_reg       <= addr_in[win_id];
            wdata_reg      <= wdata_in[win_id];
          end
        end
        ACCESS: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Per-port completion: done pulses after the owner's ACCESS cycle; rdata only moves on its own reads.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
      always_ff @(posedge CLK) begin
        if (!RESET_N) begin
          done_reg[gi]  <= 1'b0;
          rdata_reg[gi] <= '0;
        end else begin
          done_reg[gi] <= (state_reg == ACCESS) && (owner_reg == 1'(gi));
          if ((state_reg == ACCESS) && (owner_reg == 1'(gi)) && !rw_reg) begin
            rdata_reg[gi] <= bus.ddata_r;
          end
        end
      end
    end
  endgenerate

  assign bus.c_gnt   = gnt[0];
  assign bus.h_gnt   = gnt[1];
  assign bus.c_done  = done_reg[0];
  assign bus.h_done  = done_reg[1];
  assign bus.c_rdata = rdata_reg[0];
  assign bus.h_rdata = rdata_reg[1];

  // Write enable is gated by reset so an access interrupted by reset never commits.
  assign bus.daddr   = (state_reg == ACCESS) ? addr_reg  : '0;
  assign bus.ddata_w = (state_reg == ACCESS) ? wdata_reg : '0;
  assign bus.d_rw    = (state_reg == ACCESS) & rw_reg & RESET_N;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM attached to the RAM side.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] ram [0:1023];
  always @(posedge CLK) if (bus.d_rw) ram[bus.daddr] <= bus.ddata_w;
  assign bus.ddata_r = ram[bus.daddr];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit port, input bit req, input bit rw,
                       input logic [9:0] a, input logic [31:0] d);
    if (port) begin
      bus.h_req = req; bus.h_rw = rw; bus.h_addr = a; bus.h_wdata = d;
    end else begin
      bus.c_req = req; bus.c_rw = rw; bus.c_addr = a; bus.c_wdata = d;
    end
  endtask

  // Issues one access on a port; reports cycles waited for grant and grant-to-done latency (-1 on timeout).
  task automatic run_access(input bit port, input bit rw, input logic [9:0] a,
                            input logic [31:0] d, output logic [31:0] rdata,
                            output int wait_cycles, output int done_lat);
    bit granted = 0;
    bit seen = 0;
    rdata = '0;
    wait_cycles = 0;
    cyc();
    drive(port, 1'b1, rw, a, d);
    while (!granted && wait_cycles < 8) begin
      @(negedge CLK);
      if (port ? bus.h_gnt : bus.c_gnt) granted = 1;
      else begin
        wait_cycles++;
        cyc();
      end
    end
    if (!granted) begin
      drive(port, 1'b0, 1'b0, '0, '0);
      done_lat = -1;
      return;
    end
    done_lat = 0;
    while (!seen && done_lat < 6) begin
      cyc();
      if (done_lat == 0) drive(port, 1'b0, 1'b0, '0, '0);
      done_lat++;
      @(negedge CLK);
      if (port ? bus.h_done : bus.c_done) begin
        seen = 1;
        rdata = port ? bus.h_rdata : bus.c_rdata;
      end
    end
    if (!seen) done_lat = -1;
  endtask

  task automatic test_reset();
    logic [129:0] outs;
    RESET_N = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h005, 32'hAAAA5555);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      outs = {bus.d_rw, bus.c_gnt, bus.h_gnt, bus.c_done, bus.h_done, bus.daddr,
              bus.ddata_w, bus.c_rdata, bus.h_rdata};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h exp 0", i, outs);
      end
    end
    cyc();
    RESET_N = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.c_gnt, bus.h_gnt, bus.d_rw, bus.c_done} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp 0000", {bus.c_gnt, bus.h_gnt, bus.d_rw, bus.c_done});
    end
  endtask

  task automatic test_core_write_read();
    cyc();
    drive(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    @(negedge CLK);
    checks++;
    if ({bus.c_gnt, bus.d_rw} !== 2'b10) begin
      errors++;
      $display("FAIL wr_grant got gnt=%b d_rw=%b exp gnt=1 d_rw=0", bus.c_gnt, bus.d_rw);
    end
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.d_rw, bus.daddr, bus.ddata_w, bus.c_gnt} !== {1'b1, 10'h005, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL wr_access got d_rw=%b daddr=%h wdata=%h gnt=%b exp 1 005 deadbeef 0",
               bus.d_rw, bus.daddr, bus.ddata_w, bus.c_gnt);
    end
    cyc();
    drive(0, 1'b1, 1'b0, 10'h005, '0);
    @(negedge CLK);
    checks++;
    if ({bus.c_done, bus.c_gnt, bus.c_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL wr_done_regrant got done=%b gnt=%b rdata=%h exp 1 1 00000000",
               bus.c_done, bus.c_gnt, bus.c_rdata);
    end
    checks++;
    if (ram[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_ram got %h exp deadbeef", ram[5]);
    end
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.d_rw, bus.daddr, bus.c_done} !== {1'b0, 10'h005, 1'b0}) begin
      errors++;
      $display("FAIL rd_access got d_rw=%b daddr=%h done=%b exp 0 005 0", bus.d_rw, bus.daddr, bus.c_done);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if ({bus.c_done, bus.c_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rd_done got done=%b rdata=%h exp 1 deadbeef", bus.c_done, bus.c_rdata);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if ({bus.c_done, bus.c_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rd_hold got done=%b rdata=%h exp 0 deadbeef", bus.c_done, bus.c_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] exp_done;
    cyc();
    RESET_N = 1'b0;
    cyc();
    RESET_N = 1'b1;
    drive(0, 1'b1, 1'b0, 10'h005, '0);
    drive(1, 1'b1, 1'b0, 10'h007, '0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      @(negedge CLK);
      exp_gnt  = (k % 2 != 0) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
      exp_done = (k % 2 != 0 || k < 2) ? 2'b00 : (((k - 2) % 4 == 0) ? 2'b01 : 2'b10);
      checks++;
      if ({bus.h_gnt, bus.c_gnt, bus.h_done, bus.c_done} !== {exp_gnt, exp_done}) begin
        errors++;
        $display("FAIL rr_cycle%0d got hc_gnt=%b hc_done=%b exp %b %b",
                 k, {bus.h_gnt, bus.c_gnt}, {bus.h_done, bus.c_done}, exp_gnt, exp_done);
      end
      if (k == 2) begin
        checks++;
        if (bus.c_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rr_c_rdata got %h exp deadbeef", bus.c_rdata);
        end
      end
    end
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.h_gnt, bus.c_gnt, bus.h_done} !== 3'b001) begin
      errors++;
      $display("FAIL rr_drain got hc_gnt=%b h_done=%b exp 00 1", {bus.h_gnt, bus.c_gnt}, bus.h_done);
    end
  endtask

  task automatic test_host_burst();
    bit exp_gnt;
    bit exp_done;
    logic [31:0] rd;
    int wc;
    int lat;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      if (k % 2 == 0 && k < 16) drive(1, 1'b1, 1'b1, 10'(k / 2), 32'(3 * (k / 2)));
      else drive(1, 1'b0, 1'b0, '0, '0);
      @(negedge CLK);
      exp_gnt  = (k % 2 == 0) && (k < 16);
      exp_done = (k % 2 == 0) && (k >= 2);
      checks++;
      if ({bus.h_gnt, bus.h_done} !== {exp_gnt, exp_done}) begin
        errors++;
        $display("FAIL burst_cycle%0d got gnt=%b done=%b exp %b %b", k, bus.h_gnt, bus.h_done, exp_gnt, exp_done);
      end
    end
    run_access(0, 1'b0, 10'h007, '0, rd, wc, lat);
    checks++;
    if ({rd, 8'(wc), 8'(lat)} !== {32'd21, 8'd0, 8'd2}) begin
      errors++;
      $display("FAIL burst_readback got rdata=%0d wait=%0d lat=%0d exp 21 0 2", rd, wc, lat);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int wc;
    int lat;
    run_access(1, 1'b1, 10'h010, 32'h1, rd, wc, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL abort_preload got lat=%0d exp 2", lat);
    end
    cyc();
    drive(1, 1'b1, 1'b1, 10'h010, 32'h0000ABCD);
    @(negedge CLK);
    checks++;
    if (bus.h_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_grant got %b exp 1", bus.h_gnt);
    end
    cyc();
    drive(1, 1'b0, 1'b0, '0, '0);
    RESET_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.d_rw !== 1'b0) begin
      errors++;
      $display("FAIL abort_d_rw got %b exp 0", bus.d_rw);
    end
    cyc();
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.h_done, bus.h_rdata, ram[16]} !== {1'b0, 32'h0, 32'h1}) begin
      errors++;
      $display("FAIL abort_after got done=%b h_rdata=%h ram=%h exp 0 00000000 00000001",
               bus.h_done, bus.h_rdata, ram[16]);
    end
    run_access(0, 1'b0, 10'h010, '0, rd, wc, lat);
    checks++;
    if ({rd, 8'(wc), 8'(lat)} !== {32'h1, 8'd0, 8'd2}) begin
      errors++;
      $display("FAIL abort_readback got rdata=%h wait=%0d lat=%0d exp 00000001 0 2", rd, wc, lat);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] rd;
    int wc;
    int lat;
    run_access(1, 1'b1, 10'h000, 32'h12345678, rd, wc, lat);
    run_access(1, 1'b0, 10'h000, '0, rd, wc, lat);
    checks++;
    if ({rd, 8'(lat)} !== {32'h12345678, 8'd2}) begin
      errors++;
      $display("FAIL bnd_host_read got rdata=%h lat=%0d exp 12345678 2", rd, lat);
    end
    cyc();
    drive(0, 1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF);
    drive(1, 1'b1, 1'b0, 10'h000, '0);
    @(negedge CLK);
    checks++;
    if ({bus.h_gnt, bus.c_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL bnd_tie got hc_gnt=%b exp 01", {bus.h_gnt, bus.c_gnt});
    end
    cyc();
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.h_gnt, bus.d_rw, bus.daddr, bus.ddata_w} !== {2'b01, 10'h3FF, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL bnd_c_access got h_gnt=%b d_rw=%b daddr=%h wdata=%h exp 0 1 3ff ffffffff",
               bus.h_gnt, bus.d_rw, bus.daddr, bus.ddata_w);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if ({bus.c_done, bus.h_gnt} !== 2'b11) begin
      errors++;
      $display("FAIL bnd_c_done_h_gnt got c_done=%b h_gnt=%b exp 1 1", bus.c_done, bus.h_gnt);
    end
    cyc();
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    checks++;
    if ({bus.d_rw, bus.daddr} !== {1'b0, 10'h000}) begin
      errors++;
      $display("FAIL bnd_h_access got d_rw=%b daddr=%h exp 0 000", bus.d_rw, bus.daddr);
    end
    cyc();
    @(negedge CLK);
    checks++;
    if ({bus.h_done, bus.h_rdata, bus.c_rdata} !== {1'b1, 32'h12345678, 32'h1}) begin
      errors++;
      $display("FAIL bnd_h_done got done=%b h_rdata=%h c_rdata=%h exp 1 12345678 00000001",
               bus.h_done, bus.h_rdata, bus.c_rdata);
    end
    run_access(0, 1'b0, 10'h3FF, '0, rd, wc, lat);
    checks++;
    if ({rd, bus.h_rdata, 8'(lat)} !== {32'hFFFFFFFF, 32'h12345678, 8'd2}) begin
      errors++;
      $display("FAIL bnd_c_read got c_rdata=%h h_rdata=%h lat=%0d exp ffffffff 12345678 2",
               rd, bus.h_rdata, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_core_write_read();
    test_round_robin();
    test_host_burst();
    test_reset_abort();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
